axi_burst_addr_gen: RTL

- Expands one accepted AXI address-phase request (AW or AR) into a per-beat stream of address, byte strobe, beat index and last flag.
- Sits between the address-channel capture stage and the data-channel drive/sample logic in the AXI slave and monitor.
- Consumes the team's common AXI burst size, burst type and resp encodings.
- Supports FIXED, INCR and WRAP bursts per AXI3/AXI4 address rules.

---
 rtl/axi_burst_addr_gen.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/axi_burst_addr_gen.sv
// axi_burst_addr_gen
//
// Turns one accepted AXI address-phase request (AW or AR) into a stream of
// per-beat address, byte strobe, beat index and last flag. FIXED, INCR and
// WRAP bursts follow the AXI3/AXI4 address rules. The reserved burst type
// produces INCR addresses.
//
// Optional feature macro: AXI_BURST_ERR_CHK_EN
//   defined   : beat_resp is SLVERR for every beat of an illegal burst.
//               A burst is illegal if it has a reserved type, a beat size
//               wider than the bus, a WRAP length outside {1,3,7,15}, an
//               unaligned WRAP start, or an INCR that crosses a 4 KB boundary.
//   undefined : beat_resp is always OKAY and no check logic is built.
//
// Ports
//   ACLK, ARESETn       clock (rising edge), synchronous active-low reset
//   req_valid/req_ready request handshake
//   req_addr/len/size/burst/id   request fields
//   beat_valid/beat_ready        beat handshake
//   beat_addr/strb/idx/last/id/resp  per-beat outputs
module axi_burst_addr_gen #(
  parameter int ADDR_W     = 32,
  parameter int DATA_BYTES = 4,
  parameter int ID_W       = 4,
  parameter int LEN_W      = 8
) (
  input  logic                  ACLK,
  input  logic                  ARESETn,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [ADDR_W-1:0]     req_addr,
  input  logic [LEN_W-1:0]      req_len,
  input  logic [2:0]            req_size,
  input  logic [1:0]            req_burst,
  input  logic [ID_W-1:0]       req_id,
  output logic                  beat_valid,
  input  logic                  beat_ready,
  output logic [ADDR_W-1:0]     beat_addr,
  output logic [DATA_BYTES-1:0] beat_strb,
  output logic [LEN_W-1:0]      beat_idx,
  output logic                  beat_last,
  output logic [ID_W-1:0]       beat_id,
  output logic [1:0]            beat_resp
);

  typedef enum logic [0:0] {IDLE, BURST} state_t;

  state_t state, state_next;

  logic [ADDR_W-1:0] cur_addr, wrap_lower, wrap_bytes;
  logic [LEN_W-1:0]  lat_len, idx;
  logic [2:0]        lat_size;
  logic [1:0]        lat_burst;
  logic [ID_W-1:0]   lat_id;

  logic req_fire, beat_fire, is_last, busy;
  logic [ADDR_W-1:0] beat_bytes, cur_aligned, wrap_next, next_addr;
  logic [ADDR_W-1:0] req_wrap_bytes;
  logic [31:0] lane_off, lane_end;
  logic [DATA_BYTES-1:0] strb_calc;

  localparam logic [ADDR_W-1:0] DB_MASK = ADDR_W'(DATA_BYTES - 1);

  assign busy      = (state == BURST);
  assign req_fire  = req_valid & req_ready;
  assign beat_fire = busy & beat_ready;
  assign is_last   = (idx == lat_len);

  // Wrap window size in bytes: bytes per beat times number of beats.
  assign req_wrap_bytes = (ADDR_W'(req_len) + ADDR_W'(1)) << req_size;

  // State register
  always_ff @(posedge ACLK) begin
    if (!ARESETn) state <= IDLE;
    else          state <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:  if (req_fire) state_next = BURST;
      BURST: if (beat_fire && is_last) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Address of the following beat
  always_comb begin
    beat_bytes  = ADDR_W'(1) << lat_size;
    cur_aligned = cur_addr & ~(beat_bytes - ADDR_W'(1));
    wrap_next   = cur_addr + beat_bytes;
    unique case (lat_burst)
      2'd0:    next_addr = cur_addr;
      2'd2:    next_addr = (wrap_next == wrap_lower + wrap_bytes) ? wrap_lower : wrap_next;
      default: next_addr = cur_aligned + beat_bytes;
    endcase
  end

  // Byte lanes: from the address offset up to the end of the aligned beat,
  // clipped at the top of the bus.
  always_comb begin
    lane_off  = 32'(cur_addr & DB_MASK);
    lane_end  = 32'(cur_aligned & DB_MASK) + (32'd1 << lat_size) - 32'd1;
    strb_calc = '0;
    for (int i = 0; i < DATA_BYTES; i++)
      strb_calc[i] = (32'(i) >= lane_off) && (32'(i) <= lane_end);
  end

  // Burst context and beat counter
  always_ff @(posedge ACLK) begin
    if (!ARESETn) begin
      cur_addr   <= '0;
      wrap_lower <= '0;
      wrap_bytes <= '0;
      lat_len    <= '0;
      lat_size   <= '0;
      lat_burst  <= '0;
      lat_id     <= '0;
      idx        <= '0;
    end else if (req_fire) begin
      cur_addr   <= req_addr;
      wrap_lower <= req_addr & ~(req_wrap_bytes - ADDR_W'(1));
      wrap_bytes <= req_wrap_bytes;
      lat_len    <= req_len;
      lat_size   <= req_size;
      lat_burst  <= req_burst;
      lat_id     <= req_id;
      idx        <= '0;
    end else if (beat_fire && !is_last) begin
      cur_addr <= next_addr;
      idx      <= idx + LEN_W'(1);
    end
  end

`ifdef AXI_BURST_ERR_CHK_EN
  logic [1:0]        resp_q;
  logic              req_err;
  logic [ADDR_W-1:0] req_bytes, req_aligned, req_last_addr;

  // Legality of the incoming request, decided once at acceptance
  always_comb begin
    req_bytes     = ADDR_W'(1) << req_size;
    req_aligned   = req_addr & ~(req_bytes - ADDR_W'(1));
    req_last_addr = req_aligned + (ADDR_W'(req_len) << req_size);
    req_err = (req_burst == 2'd3)
           || (req_bytes > ADDR_W'(DATA_BYTES))
           || ((req_burst == 2'd2) && !((req_len == LEN_W'(1)) || (req_len == LEN_W'(3))
                                     || (req_len == LEN_W'(7)) || (req_len == LEN_W'(15))))
           || ((req_burst == 2'd2) && ((req_addr & (req_bytes - ADDR_W'(1))) != '0))
           || ((req_burst == 2'd1) && (req_aligned[ADDR_W-1:12] != req_last_addr[ADDR_W-1:12]));
  end

  always_ff @(posedge ACLK) begin
    if (!ARESETn)      resp_q <= 2'd0;
    else if (req_fire) resp_q <= req_err ? 2'd2 : 2'd0;
  end

  assign beat_resp = busy ? resp_q : 2'd0;
`else
  assign beat_resp = 2'd0;
`endif

  // Output logic; beat fields read zero whenever no burst is active.
  // req_ready is held low throughout the reset cycle.
  always_comb begin
    req_ready  = ARESETn && (state == IDLE);
    beat_valid = busy;
    beat_addr  = busy ? cur_addr  : '0;
    beat_strb  = busy ? strb_calc : '0;
    beat_idx   = busy ? idx       : '0;
    beat_last  = busy && is_last;
    beat_id    = busy ? lat_id    : '0;
  end

endmodule
